// File: rtl/text_cursor_ctrl_if.sv
// -----------------------------------------------------------------------------
// text_cursor_ctrl_if
// Character-stream handshake between a text producer and text_cursor_ctrl.
//
// Signals:
//   i_char        producer -> controller, character code (CW bits)
//   i_char_valid  producer -> controller, i_char is valid
//   o_char_ready  controller -> producer, controller accepts a code this cycle
//
// Modports:
//   master : the producer side (drives code and valid)
//   slave  : the controller side (drives ready)
// -----------------------------------------------------------------------------
interface text_cursor_ctrl_if #(
    parameter int CW = 8
);
    logic [CW-1:0] i_char;
    logic          i_char_valid;
    logic          o_char_ready;

    modport master (
        output i_char,
        output i_char_valid,
        input  o_char_ready
    );

    modport slave (
        input  i_char,
        input  i_char_valid,
        output o_char_ready
    );
endinterface

// File: rtl/text_cursor_ctrl.sv
// -----------------------------------------------------------------------------
// text_cursor_ctrl
// Write-side sequencer for the character-table text overlay. Accepts character
// codes over a valid/ready handshake, keeps a cursor, turns printable codes
// into single-cycle character-table writes at the cursor and interprets
// newline (0x0A), carriage return (0x0D), backspace (0x08) and form feed
// (0x0C). Form feed (and optionally reset release) blanks the whole table.
//
// Ports:
//   i_clk           sole clock, rising edge
//   i_rst           synchronous active-high reset
//   char_if         slave side of the character handshake
//                   (i_char, i_char_valid in; o_char_ready out)
//   o_wr_en         one-cycle character-table write strobe (registered)
//   o_wr_character  code to write (registered)
//   o_wr_x_pos      write column (registered)
//   o_wr_y_pos      write row (registered)
//   o_cursor_x      current cursor column
//   o_cursor_y      current cursor row
//   o_busy          high while a clear is running
// -----------------------------------------------------------------------------
module text_cursor_ctrl #(
    parameter int COLUMNS        = 12,
    parameter int ROWS           = 2,
    parameter int FONT_NUM_CHAR  = 256,
    parameter int BLANK_CHAR     = 'h20,
    parameter bit CLEAR_ON_RESET = 1'b1,
    localparam int CW = $clog2(FONT_NUM_CHAR),
    localparam int XW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1,
    localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    text_cursor_ctrl_if.slave  char_if,
    output logic               o_wr_en,
    output logic [CW-1:0]      o_wr_character,
    output logic [XW-1:0]      o_wr_x_pos,
    output logic [YW-1:0]      o_wr_y_pos,
    output logic [XW-1:0]      o_cursor_x,
    output logic [YW-1:0]      o_cursor_y,
    output logic               o_busy
);

    localparam logic [XW-1:0] XMAX  = XW'(COLUMNS - 1);
    localparam logic [YW-1:0] YMAX  = YW'(ROWS - 1);
    localparam logic [CW-1:0] BLANK = CW'(BLANK_CHAR);
    localparam logic [CW-1:0] CH_BS = CW'('h08);
    localparam logic [CW-1:0] CH_LF = CW'('h0A);
    localparam logic [CW-1:0] CH_FF = CW'('h0C);
    localparam logic [CW-1:0] CH_CR = CW'('h0D);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t        state_q,    state_d;
    logic          init_q,     init_d;
    logic          ready_q,    ready_d;
    logic          busy_q,     busy_d;
    logic          wr_en_q,    wr_en_d;
    logic [CW-1:0] wr_char_q,  wr_char_d;
    logic [XW-1:0] wr_x_q,     wr_x_d;
    logic [YW-1:0] wr_y_q,     wr_y_d;
    logic [XW-1:0] cur_x_q,    cur_x_d;
    logic [YW-1:0] cur_y_q,    cur_y_d;
    logic [XW-1:0] clr_x_q,    clr_x_d;
    logic [YW-1:0] clr_y_q,    clr_y_d;
    logic          clr_done_q, clr_done_d;
    logic          handshake;
    logic          start_clr;

    // Compare-and-wrap increments so non-power-of-2 sizes wrap correctly.
    function automatic logic [XW-1:0] inc_x(input logic [XW-1:0] x);
        return (x == XMAX) ? '0 : x + XW'(1);
    endfunction

    function automatic logic [YW-1:0] inc_y(input logic [YW-1:0] y);
        return (y == YMAX) ? '0 : y + YW'(1);
    endfunction

    assign handshake = char_if.i_char_valid && ready_q;

    always_comb begin
        state_d    = state_q;
        init_d     = 1'b0;
        ready_d    = ready_q;
        busy_d     = busy_q;
        wr_en_d    = 1'b0;
        wr_char_d  = wr_char_q;
        wr_x_d     = wr_x_q;
        wr_y_d     = wr_y_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        clr_x_d    = clr_x_q;
        clr_y_d    = clr_y_q;
        clr_done_d = clr_done_q;
        start_clr  = 1'b0;

        if (init_q) begin
            // First active edge after reset: either blank the table or open up.
            if (CLEAR_ON_RESET) begin
                start_clr = 1'b1;
            end else begin
                ready_d = 1'b1;
            end
        end else if (state_q == S_IDLE) begin
            if (handshake) begin
                case (char_if.i_char)
                    CH_LF: begin
                        cur_x_d = '0;
                        cur_y_d = inc_y(cur_y_q);
                    end
                    CH_CR: begin
                        cur_x_d = '0;
                    end
                    CH_BS: begin
                        // Backspace at the origin is a no-op.
                        if (cur_x_q != '0 || cur_y_q != '0) begin
                            if (cur_x_q == '0) begin
                                cur_x_d = XMAX;
                                cur_y_d = cur_y_q - YW'(1);
                            end else begin
                                cur_x_d = cur_x_q - XW'(1);
                            end
                            wr_en_d   = 1'b1;
                            wr_char_d = BLANK;
                            wr_x_d    = cur_x_d;
                            wr_y_d    = cur_y_d;
                        end
                    end
                    CH_FF: begin
                        start_clr = 1'b1;
                    end
                    default: begin
                        wr_en_d   = 1'b1;
                        wr_char_d = char_if.i_char;
                        wr_x_d    = cur_x_q;
                        wr_y_d    = cur_y_q;
                        cur_x_d   = inc_x(cur_x_q);
                        if (cur_x_q == XMAX) begin
                            cur_y_d = inc_y(cur_y_q);
                        end
                    end
                endcase
            end
        end else begin
            // S_CLEAR: the cycle after the last blank write is spent still busy
            // so ready reasserts exactly one cycle after the final write.
            if (clr_done_q) begin
                state_d    = S_IDLE;
                ready_d    = 1'b1;
                busy_d     = 1'b0;
                clr_done_d = 1'b0;
            end else begin
                wr_en_d   = 1'b1;
                wr_char_d = BLANK;
                wr_x_d    = clr_x_q;
                wr_y_d    = clr_y_q;
                if (clr_x_q == XMAX && clr_y_q == YMAX) begin
                    clr_done_d = 1'b1;
                end else begin
                    clr_x_d = inc_x(clr_x_q);
                    if (clr_x_q == XMAX) begin
                        clr_y_d = inc_y(clr_y_q);
                    end
                end
            end
        end

        // Starting a clear issues the (0,0) blank immediately and points the
        // walker at the following position.
        if (start_clr) begin
            state_d   = S_CLEAR;
            ready_d   = 1'b0;
            busy_d    = 1'b1;
            wr_en_d   = 1'b1;
            wr_char_d = BLANK;
            wr_x_d    = '0;
            wr_y_d    = '0;
            cur_x_d   = '0;
            cur_y_d   = '0;
            if (COLUMNS * ROWS == 1) begin
                clr_done_d = 1'b1;
            end else begin
                clr_done_d = 1'b0;
                clr_x_d    = inc_x('0);
                clr_y_d    = (XMAX == '0) ? inc_y('0) : '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            init_q     <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_char_q  <= '0;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            clr_x_q    <= '0;
            clr_y_q    <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_q     <= init_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            wr_char_q  <= wr_char_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            clr_x_q    <= clr_x_d;
            clr_y_q    <= clr_y_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign char_if.o_char_ready = ready_q;
    assign o_wr_en        = wr_en_q;
    assign o_wr_character = wr_char_q;
    assign o_wr_x_pos     = wr_x_q;
    assign o_wr_y_pos     = wr_y_q;
    assign o_cursor_x     = cur_x_q;
    assign o_cursor_y     = cur_y_q;
    assign o_busy         = busy_q;

endmodule
